// File: rtl/sub_pkg.sv
// Shared types and constants for the button-driven BCD down-counter.
// Holds the debounce state encoding and the active-low 7-segment decode.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low patterns, bit 6 = g .. bit 0 = a; entry 0 sits in the low slice
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    if (digit <= BCD_MAX) seg = SEG_TABLE[digit];
    return seg;
  endfunction

endpackage

// File: rtl/sub_debounce.sv
// Two-flop synchroniser plus press/release debounce FSM for a raw push-button.
// Emits a registered one-cycle dec_pulse for each accepted press.
module sub_debounce
  import sub_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic dec_pulse
);

  localparam logic [15:0] DC_LAST = 16'(DEB_CYCLES - 1);

  logic       r_s1;
  logic       r_s2;
  deb_state_t r_state;
  logic [15:0] r_dc;
  logic       r_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= button;
      r_s2 <= r_s1;
    end
  end

  // Only the second synchroniser stage feeds the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_dc    <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_s2) begin
            r_state <= PRESS_WAIT;
            r_dc    <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!r_s2) begin
            r_state <= IDLE;
          end else if (r_dc == DC_LAST) begin
            r_state <= PRESSED;
            r_pulse <= 1'b1;
          end else begin
            r_dc <= r_dc + 16'd1;
          end
        end
        PRESSED: begin
          if (!r_s2) begin
            r_state <= RELEASE_WAIT;
            r_dc    <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (r_s2) begin
            r_state <= PRESSED;
          end else if (r_dc == DC_LAST) begin
            r_state <= IDLE;
          end else begin
            r_dc <= r_dc + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dec_pulse = r_pulse;

endmodule

// File: rtl/sub_ctrl.sv
// Two-digit BCD down-counter driven by debounced presses, with borrow on 00->99
// and a time-multiplexed, registered 7-segment display drive.
module sub_ctrl
  import sub_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int SCAN_CYCLES = 8,
  parameter int START_HI    = 9,
  parameter int START_LO    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  output logic [6:0] leds,
  output logic [1:0] an,
  output logic [7:0] count,
  output logic       dec_pulse,
  output logic       borrow
);

  localparam int          SCAN_W    = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic              w_dec;
  logic [3:0]        r_tens;
  logic [3:0]        r_ones;
  logic              r_borrow;
  logic              r_sel;
  logic [SCAN_W-1:0] r_scan;
  logic [1:0]        r_an;
  logic [6:0]        r_leds;

  sub_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .button   (button),
    .dec_pulse(w_dec)
  );

  // BCD decrement with borrow/wrap; borrow strobes with the 99 reload
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tens   <= 4'(START_HI);
      r_ones   <= 4'(START_LO);
      r_borrow <= 1'b0;
    end else begin
      r_borrow <= 1'b0;
      if (w_dec) begin
        if (r_ones != 4'd0) begin
          r_ones <= r_ones - 4'd1;
        end else if (r_tens != 4'd0) begin
          r_ones <= BCD_MAX;
          r_tens <= r_tens - 4'd1;
        end else begin
          r_ones   <= BCD_MAX;
          r_tens   <= BCD_MAX;
          r_borrow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan <= '0;
      r_sel  <= 1'b0;
      r_an   <= 2'b00;
      r_leds <= SEG_BLANK;
    end else begin
      if (r_scan == SCAN_LAST) begin
        r_scan <= '0;
        r_sel  <= ~r_sel;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
      r_an   <= r_sel ? 2'b10 : 2'b01;
      r_leds <= seg_decode(r_sel ? r_tens : r_ones);
    end
  end

  assign count     = {r_tens, r_ones};
  assign borrow    = r_borrow;
  assign dec_pulse = w_dec;
  assign an        = r_an;
  assign leds      = r_leds;

endmodule

// File: tb/tb_sub_ctrl.sv
// Scoreboard bench for sub_ctrl: each accepted press pushes the expected
// {borrow, count}; a negedge monitor pops and compares after each dec_pulse.
module tb_sub_ctrl;

  logic       clk;
  logic       reset;
  logic       button;
  logic [6:0] leds;
  logic [1:0] an;
  logic [7:0] count;
  logic       dec_pulse;
  logic       borrow;

  int n_total = 0;
  int n_bad   = 0;
  int n_pulses = 0;
  logic [8:0] sb[$];
  logic [7:0] m_count;
  logic       pulse_d;
  logic       pulse_d2;

  logic [6:0] seg_exp [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  sub_ctrl #(
    .DEB_CYCLES (4),
    .SCAN_CYCLES(8),
    .START_HI   (9),
    .START_LO   (9)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .button   (button),
    .leds     (leds),
    .an       (an),
    .count    (count),
    .dec_pulse(dec_pulse),
    .borrow   (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] bcd_next(input logic [7:0] c);
    int v;
    v = int'(c[7:4]) * 10 + int'(c[3:0]);
    if (v == 0) return {1'b1, 8'h99};
    v = v - 1;
    return {1'b0, 4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic expect_dec();
    logic [8:0] e;
    e = bcd_next(m_count);
    sb.push_back(e);
    m_count = e[7:0];
  endtask

  task automatic press(input int hi, input int lo);
    expect_dec();
    @(posedge clk); #1 button = 1'b1;
    repeat (hi) @(posedge clk);
    #1 button = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic press_until(input logic [7:0] target);
    for (int i = 0; i < 200 && m_count != target; i++) press(8, 10);
    chk_eq("reach_target", m_count, target);
  endtask

  // Scoreboard monitor: dec_pulse seen at one negedge means the update is visible at the next
  initial begin
    logic [8:0] e;
    pulse_d  = 1'b0;
    pulse_d2 = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pulse_d  = 1'b0;
        pulse_d2 = 1'b0;
      end else begin
        if (pulse_d) begin
          if (sb.size() == 0) begin
            chk_eq("sb_unexpected_pulse", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk_eq("sb_count", count, e[7:0]);
            chk_eq("sb_borrow", borrow, e[8]);
          end
        end
        if (pulse_d2) chk_eq("borrow_one_cycle", borrow, 0);
        if (dec_pulse) begin
          n_pulses++;
          chk_eq("pulse_width", pulse_d, 0);
        end
        pulse_d2 = pulse_d;
        pulse_d  = dec_pulse;
      end
    end
  end

  initial begin
    int p0;
    int lat;
    int run;
    logic [1:0] prev_an;
    bit seen_change;

    reset   = 1'b1;
    button  = 1'b0;
    m_count = 8'h99;

    // 1: reset values, then first display output
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_count", count, 8'h99);
    chk_eq("rst_an", an, 2'b00);
    chk_eq("rst_leds", leds, 7'b1111111);
    chk_eq("rst_pulse", dec_pulse, 0);
    chk_eq("rst_borrow", borrow, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_eq("first_an", an, 2'b01);
    chk_eq("first_leds", leds, 7'b0010000);

    // 2: short glitch is rejected
    p0 = n_pulses;
    @(posedge clk); #1 button = 1'b1;
    repeat (3) @(posedge clk);
    #1 button = 1'b0;
    repeat (15) @(posedge clk);
    chk_eq("glitch_pulses", n_pulses - p0, 0);
    chk_eq("glitch_count", count, 8'h99);

    // 3: clean press, latency to dec_pulse
    p0 = n_pulses;
    lat = 0;
    expect_dec();
    @(posedge clk); #1 button = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (dec_pulse && lat == 0) lat = k;
    end
    button = 1'b0;
    repeat (20) @(posedge clk);
    chk_eq("press_latency", lat, 7);
    chk_eq("press_pulses", n_pulses - p0, 1);
    chk_eq("press_count", count, 8'h98);

    // 4: bouncy release yields a single decrement
    p0 = n_pulses;
    expect_dec();
    @(posedge clk); #1 button = 1'b1;
    repeat (10) @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      #1 button = ~button;
      @(posedge clk);
    end
    #1 button = 1'b0;
    repeat (20) @(posedge clk);
    chk_eq("bounce_pulses", n_pulses - p0, 1);
    chk_eq("bounce_count", count, 8'h97);

    // 5: tens borrow and 00 -> 99 wrap
    press_until(8'h10);
    press(8, 10);
    chk_eq("tens_borrow_count", count, 8'h09);
    press_until(8'h00);
    press(8, 10);
    chk_eq("wrap_count", count, 8'h99);

    // 6: display scan at 42
    press_until(8'h42);
    repeat (5) @(posedge clk);
    @(negedge clk);
    prev_an = an;
    run = 1;
    seen_change = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk_eq("scan_onehot", (an == 2'b01 || an == 2'b10), 1);
      chk_eq("scan_leds", leds, (an == 2'b10) ? seg_exp[4] : seg_exp[2]);
      if (an == prev_an) begin
        run++;
      end else begin
        if (seen_change) chk_eq("scan_len", run, 8);
        seen_change = 1'b1;
        run = 1;
      end
      prev_an = an;
    end

    // reset during PRESS_WAIT with button released: no decrement
    p0 = n_pulses;
    @(posedge clk); #1 button = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1; button = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_count = 8'h99;
    repeat (20) @(posedge clk);
    chk_eq("midreset_pulses", n_pulses - p0, 0);
    chk_eq("midreset_count", count, 8'h99);

    // button held across reset: debounced afresh, one decrement
    p0 = n_pulses;
    @(posedge clk); #1 button = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expect_dec();
    repeat (12) @(posedge clk);
    #1 button = 1'b0;
    repeat (15) @(posedge clk);
    chk_eq("held_reset_pulses", n_pulses - p0, 1);
    chk_eq("held_reset_count", count, 8'h98);

    chk_eq("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
